inv_rounds_engine: RTL

Iterative AES-128 decryption core. It applies the FIPS-197 inverse cipher to one 128-bit ciphertext block at a time, reusing a single round datapath for rounds 10 down to 0. It is the decrypt-side counterpart of the encryption round stages. It sits between a ciphertext source and a plaintext sink, both using valid/ready handshakes. It fetches round keys one per cycle by index from an external, already-expanded round-key store.

---
 rtl/inv_rounds_engine.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/inv_rounds_engine.sv
// inv_rounds_engine: iterative AES-128 decryption core.
// One shared inverse-round datapath is stepped through rounds 10..0, one round per clock.
// Round keys come from an external, already-expanded key store addressed by rk_idx.
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready     ciphertext handshake, in_data byte 0 at [127:120]
//   rk_idx/rk_in          round-key index out, key returned combinationally
//   out_valid/out_ready   plaintext handshake, out_data registered
//   busy                  high while rounds are in flight (ROUND, FINAL)
module inv_rounds_engine #(
    parameter int unsigned BLOCK_LENGTH = 128
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BLOCK_LENGTH-1:0] in_data,
    output logic [3:0]              rk_idx,
    input  logic [BLOCK_LENGTH-1:0] rk_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BLOCK_LENGTH-1:0] out_data,
    output logic                    busy
);

    typedef enum logic [1:0] {StIdle, StRound, StFinal, StDone} fsm_e;

    fsm_e                    fsm_q;
    logic [3:0]              rnd_q;
    logic [BLOCK_LENGTH-1:0] state_q;
    logic [127:0]            pre_mix;
    logic [127:0]            inner_out;

    // ---------------- GF(2^8) helpers, polynomial 0x11B ----------------
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] acc;
        p   = a;
        acc = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // x^254 = x^-1 for x != 0 and 0 for x == 0
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    // Inverse S-box: undo the affine map first, then take the field inverse
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] a;
        for (int i = 0; i < 8; i++) begin
            a[i] = b[(i + 2) % 8] ^ b[(i + 5) % 8] ^ b[(i + 7) % 8];
        end
        return gf_inv(a ^ 8'h05);
    endfunction

    // ---------------- Round transforms (byte k: row k%4, column k/4) ----------------
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c - r + 4) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[127 - 8 * i -: 8] = inv_sbox(s[127 - 8 * i -: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] key_add(input logic [127:0] s, input logic [127:0] k);
        return s ^ k;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32 * c -: 8];
            a1 = s[119 - 32 * c -: 8];
            a2 = s[111 - 32 * c -: 8];
            a3 = s[103 - 32 * c -: 8];
            o[127 - 32 * c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^
                                   gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119 - 32 * c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^
                                   gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111 - 32 * c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^
                                   gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103 - 32 * c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^
                                   gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    // Final round is the inner round without InvMixColumns, so share the front half
    always_comb begin
        pre_mix   = key_add(inv_sub_bytes(inv_shift_rows(state_q)), rk_in);
        inner_out = inv_mix_columns(pre_mix);
    end

    // ---------------- Control outputs ----------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        rk_idx    = 4'd10;
        unique case (fsm_q)
            StIdle:  in_ready = 1'b1;
            StRound: begin
                busy   = 1'b1;
                rk_idx = rnd_q;
            end
            StFinal: begin
                busy   = 1'b1;
                rk_idx = 4'd0;
            end
            StDone: begin
                out_valid = 1'b1;
                // A block can be taken in the same cycle the result is handed off
                in_ready  = out_ready;
            end
            default: ;
        endcase
    end

    // ---------------- FSM and datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q    <= StIdle;
            rnd_q    <= 4'd0;
            state_q  <= '0;
            out_data <= '0;
        end else begin
            unique case (fsm_q)
                StIdle: begin
                    if (in_valid) begin
                        state_q <= in_data ^ rk_in;
                        rnd_q   <= 4'd9;
                        fsm_q   <= StRound;
                    end
                end
                StRound: begin
                    state_q <= inner_out;
                    if (rnd_q == 4'd1) fsm_q <= StFinal;
                    else               rnd_q <= rnd_q - 4'd1;
                end
                StFinal: begin
                    out_data <= pre_mix;
                    fsm_q    <= StDone;
                end
                StDone: begin
                    if (out_ready) begin
                        if (in_valid) begin
                            state_q <= in_data ^ rk_in;
                            rnd_q   <= 4'd9;
                            fsm_q   <= StRound;
                        end else begin
                            fsm_q <= StIdle;
                        end
                    end
                end
                default: fsm_q <= StIdle;
            endcase
        end
    end

endmodule
